// File: rtl/rgb_timing_gen_pkg.sv
// rtl/rgb_timing_gen_pkg.sv - shared phase encodings, coordinate width and default panel timing
package rgb_timing_gen_pkg;

  localparam int COORD_W = 11;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_H_SYNC   = 4;
  localparam int DEF_H_BP     = 43;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 8;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 12;

  // Bit 2 marks the parked state; the low two bits are the running phase.
  typedef enum logic [2:0] {
    PH_SYNC = 3'd0,
    PH_BP   = 3'd1,
    PH_ACT  = 3'd2,
    PH_FP   = 3'd3,
    PH_IDLE = 3'd4
  } phase_e;

endpackage

// File: rtl/rgb_phase_cnt.sv
// rtl/rgb_phase_cnt.sv - sync/back-porch/active/front-porch phase FSM with dwell counter
module rgb_phase_cnt
  import rgb_timing_gen_pkg::*;
#(
  parameter int D_SYNC = 1,
  parameter int D_BP   = 1,
  parameter int D_ACT  = 1,
  parameter int D_FP   = 1
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               adv,
  input  logic               run,
  output phase_e             phase,
  output phase_e             phase_nxt,
  output logic [COORD_W-1:0] cnt_nxt,
  output logic               done
);

  localparam logic [COORD_W-1:0] SYNC_LAST = COORD_W'(D_SYNC - 1);
  localparam logic [COORD_W-1:0] BP_LAST   = COORD_W'(D_BP - 1);
  localparam logic [COORD_W-1:0] ACT_LAST  = COORD_W'(D_ACT - 1);
  localparam logic [COORD_W-1:0] FP_LAST   = COORD_W'(D_FP - 1);

  phase_e             phase_q, phase_d;
  logic [COORD_W-1:0] cnt_q, cnt_d;
  logic [COORD_W-1:0] last_cnt;
  logic               at_last;

  always_comb begin
    case (phase_q)
      PH_SYNC: last_cnt = SYNC_LAST;
      PH_BP:   last_cnt = BP_LAST;
      PH_ACT:  last_cnt = ACT_LAST;
      PH_FP:   last_cnt = FP_LAST;
      default: last_cnt = '0;
    endcase
    at_last = (cnt_q == last_cnt);

    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (adv) begin
      if (phase_q == PH_IDLE) begin
        if (run) begin
          phase_d = PH_SYNC;
          cnt_d   = '0;
        end
      end else if (at_last) begin
        cnt_d = '0;
        case (phase_q)
          PH_SYNC: phase_d = PH_BP;
          PH_BP:   phase_d = PH_ACT;
          PH_ACT:  phase_d = PH_FP;
          default: phase_d = run ? PH_SYNC : PH_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase     = phase_q;
  assign phase_nxt = phase_d;
  assign cnt_nxt   = cnt_d;
  assign done      = (phase_q == PH_FP) && at_last;

endmodule

// File: rtl/rgb_timing_gen.sv
// rtl/rgb_timing_gen.sv - RGB panel HS/VS/DE timing generator driven by a divided pixel clock
module rgb_timing_gen
  import rgb_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               PCLK_IN,
  input  logic               EN,
  output logic               PIX_EN,
  output logic               LCD_HS,
  output logic               LCD_VS,
  output logic               LCD_DE,
  output logic               PIX_REQ,
  output logic [COORD_W-1:0] PIX_X,
  output logic [COORD_W-1:0] PIX_Y,
  output logic               FRAME_START
);

  localparam logic [COORD_W-1:0] H_BP_LAST  = COORD_W'(H_BP - 1);
  localparam logic [COORD_W-1:0] H_ACT_LAST = COORD_W'(H_ACTIVE - 1);

  logic               pclk_prev_q, pclk_prev_d;
  logic               pix_en;
  phase_e             h_ph, h_ph_n, v_ph, v_ph_n;
  logic [COORD_W-1:0] h_cnt_n, v_cnt_n;
  logic               h_done, v_done, h_run, v_adv;

  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, req_q, req_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  assign pclk_prev_d = PCLK_IN;
  assign pix_en      = PCLK_IN & ~pclk_prev_q;

  // EN only matters while parked or on the very last slot of a frame.
  assign h_run = ((v_ph == PH_IDLE) || v_done) ? EN : 1'b1;
  assign v_adv = pix_en & (h_done | (h_ph == PH_IDLE));

  rgb_phase_cnt #(
    .D_SYNC (H_SYNC),
    .D_BP   (H_BP),
    .D_ACT  (H_ACTIVE),
    .D_FP   (H_FP)
  ) u_h (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .adv       (pix_en),
    .run       (h_run),
    .phase     (h_ph),
    .phase_nxt (h_ph_n),
    .cnt_nxt   (h_cnt_n),
    .done      (h_done)
  );

  rgb_phase_cnt #(
    .D_SYNC (V_SYNC),
    .D_BP   (V_BP),
    .D_ACT  (V_ACTIVE),
    .D_FP   (V_FP)
  ) u_v (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .adv       (v_adv),
    .run       (EN),
    .phase     (v_ph),
    .phase_nxt (v_ph_n),
    .cnt_nxt   (v_cnt_n),
    .done      (v_done)
  );

  // Outputs are decoded from the next position so they switch on the PIX_EN edge.
  always_comb begin
    hs_d  = (h_ph_n != PH_SYNC);
    vs_d  = (v_ph_n != PH_SYNC);
    de_d  = (h_ph_n == PH_ACT) && (v_ph_n == PH_ACT);
    req_d = 1'b0;
    x_d   = '0;
    y_d   = '0;
    if (v_ph_n == PH_ACT) begin
      if ((h_ph_n == PH_BP) && (h_cnt_n == H_BP_LAST)) begin
        req_d = 1'b1;
        y_d   = v_cnt_n;
      end else if ((h_ph_n == PH_ACT) && (h_cnt_n != H_ACT_LAST)) begin
        req_d = 1'b1;
        x_d   = h_cnt_n + COORD_W'(1);
        y_d   = v_cnt_n;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pclk_prev_q <= 1'b1;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      de_q        <= 1'b0;
      req_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      pclk_prev_q <= pclk_prev_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      req_q       <= req_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign PIX_EN      = pix_en;
  assign LCD_HS      = hs_q;
  assign LCD_VS      = vs_q;
  assign LCD_DE      = de_q;
  assign PIX_REQ     = req_q;
  assign PIX_X       = x_q;
  assign PIX_Y       = y_q;
  assign FRAME_START = pix_en && (h_ph_n == PH_SYNC) && (h_cnt_n == '0)
                              && (v_ph_n == PH_SYNC) && (v_cnt_n == '0);

endmodule

// File: tb/tb_rgb_timing_gen.sv
// tb/tb_rgb_timing_gen.sv - scoreboard bench for rgb_timing_gen on a tiny 7x5-slot panel
module tb_rgb_timing_gen;

  localparam int HA = 4, HF = 1, HS = 1, HB = 1;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        pe;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        de;
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
  } obs_t;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        PCLK_IN = 1'b1;
  logic        EN = 1'b1;
  logic        PIX_EN, LCD_HS, LCD_VS, LCD_DE, PIX_REQ, FRAME_START;
  logic [10:0] PIX_X, PIX_Y;

  int   nvec = 0;
  int   nerr = 0;
  int   mpos = -1;
  obs_t sb[$];

  rgb_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .PCLK_IN     (PCLK_IN),
    .EN          (EN),
    .PIX_EN      (PIX_EN),
    .LCD_HS      (LCD_HS),
    .LCD_VS      (LCD_VS),
    .LCD_DE      (LCD_DE),
    .PIX_REQ     (PIX_REQ),
    .PIX_X       (PIX_X),
    .PIX_Y       (PIX_Y),
    .FRAME_START (FRAME_START)
  );

  always #5 CLK = ~CLK;

  // Expected outputs for frame slot pos (-1 = parked) from line/column arithmetic.
  function automatic obs_t model(int pos);
    obs_t e;
    int   h, l;
    logic vact;
    e = '0;
    e.pe = 1'b1;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (pos >= 0) begin
      h    = pos % HT;
      l    = pos / HT;
      vact = (l >= VS + VB) && (l < VS + VB + VA);
      e.fs = (pos == 0);
      e.hs = !(h < HS);
      e.vs = !(l < VS);
      e.de = vact && (h >= HS + HB) && (h < HS + HB + HA);
      if (vact && (h >= HS + HB - 1) && (h <= HS + HB + HA - 2)) begin
        e.req = 1'b1;
        e.x   = 11'(h - (HS + HB - 1));
        e.y   = 11'(l - (VS + VB));
      end
    end
    return e;
  endfunction

  function automatic obs_t now_obs();
    obs_t o;
    o = {PIX_EN, FRAME_START, LCD_HS, LCD_VS, LCD_DE, PIX_REQ, PIX_X, PIX_Y};
    return o;
  endfunction

  // One PCLK_IN period (2 CLK low, 2 CLK high); pushes the model's expectation.
  task automatic drive_slot(output obs_t got);
    obs_t o;
    @(negedge CLK); PCLK_IN = 1'b0;
    @(negedge CLK);
    @(negedge CLK); PCLK_IN = 1'b1;
    #1;
    o = now_obs();
    got.pe = o.pe;
    got.fs = o.fs;
    if (mpos < 0 || mpos == FRAME - 1) mpos = EN ? 0 : -1;
    else mpos++;
    sb.push_back(model(mpos));
    @(negedge CLK);
    o = now_obs();
    got.hs  = o.hs;
    got.vs  = o.vs;
    got.de  = o.de;
    got.req = o.req;
    got.x   = o.x;
    got.y   = o.y;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    RSTn = 1'b0; PCLK_IN = 1'b1; EN = 1'b1;
    repeat (3) @(negedge CLK);
    exp = '0; exp.hs = 1'b1; exp.vs = 1'b1;
    got = now_obs();
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL reset_state got %h exp %h", got, exp); end
    RSTn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      got = now_obs();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL release_no_pix_en cyc %0d got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_frame();
    obs_t got, exp;
    int   n_hs, n_vs, n_de, n_req_de;
    logic prev_req;
    for (int f = 0; f < 2; f++) begin
      n_hs = 0; n_vs = 0; n_de = 0; n_req_de = 0; prev_req = 1'b0;
      for (int s = 0; s < FRAME; s++) begin
        drive_slot(got);
        exp = sb.pop_front();
        nvec++;
        if (got !== exp) begin nerr++; $display("FAIL frame%0d slot %0d got %h exp %h", f, s, got, exp); end
        n_hs += got.hs ? 0 : 1;
        n_vs += got.vs ? 0 : 1;
        n_de += got.de ? 1 : 0;
        if (got.de && prev_req) n_req_de++;
        prev_req = got.req;
      end
      nvec++;
      if (n_hs != VT) begin nerr++; $display("FAIL hs_low_count got %0d exp %0d", n_hs, VT); end
      nvec++;
      if (n_vs != HT * VS) begin nerr++; $display("FAIL vs_low_count got %0d exp %0d", n_vs, HT * VS); end
      nvec++;
      if (n_de != HA * VA) begin nerr++; $display("FAIL de_count got %0d exp %0d", n_de, HA * VA); end
      nvec++;
      if (n_req_de != HA * VA) begin nerr++; $display("FAIL req_leads_de got %0d exp %0d", n_req_de, HA * VA); end
    end
  endtask

  task automatic test_stall();
    obs_t got, exp, hold, cur;
    for (int s = 0; s < 17; s++) begin
      drive_slot(got);
      exp = sb.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL stall_pre slot %0d got %h exp %h", s, got, exp); end
    end
    hold = got; hold.pe = 1'b0; hold.fs = 1'b0;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      PCLK_IN = 1'(lvl);
      for (int c = 0; c < 20; c++) begin
        @(negedge CLK);
        cur = now_obs();
        nvec++;
        if (cur !== hold) begin nerr++; $display("FAIL stall_level%0d cyc %0d got %h exp %h", lvl, c, cur, hold); end
      end
    end
    for (int s = 0; s < 8; s++) begin
      drive_slot(got);
      exp = sb.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL stall_resume slot %0d got %h exp %h", s, got, exp); end
    end
  endtask

  task automatic test_en_drop();
    obs_t got, exp;
    for (int g = 0; g < 2 * FRAME && mpos != FRAME - 1; g++) begin
      drive_slot(got);
      exp = sb.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL en_align got %h exp %h", got, exp); end
    end
    for (int s = 0; s < FRAME + 3; s++) begin
      if (s == 10) EN = 1'b0;
      drive_slot(got);
      exp = sb.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL en_drop slot %0d got %h exp %h", s, got, exp); end
    end
    EN = 1'b1;
    drive_slot(got);
    exp = sb.pop_front();
    nvec++;
    if (got !== exp) begin nerr++; $display("FAIL en_restart got %h exp %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    logic [3:0] sig;
    got = '0;
    for (int s = 0; s < 2 * FRAME && !got.de; s++) begin
      drive_slot(got);
      exp = sb.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL rst_mid_pre slot %0d got %h exp %h", s, got, exp); end
    end
    nvec++;
    if (!got.de) begin nerr++; $display("FAIL rst_mid_reach_de got 0 exp 1"); end
    #2;
    RSTn = 1'b0;
    #1;
    sig = {LCD_DE, LCD_HS, LCD_VS, PIX_REQ};
    nvec++;
    if (sig !== 4'b0110) begin nerr++; $display("FAIL rst_async de_hs_vs_req got %b exp 0110", sig); end
    mpos = -1;
    @(negedge CLK);
    RSTn = 1'b1;
    for (int s = 0; s < 3; s++) begin
      drive_slot(got);
      exp = sb.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL rst_restart slot %0d got %h exp %h", s, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rgb_timing_gen.md
RGB_TIMING_GEN -- requirements
Module: rgb_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 480, visible pixels per line.
REQ-002 Parameter H_FP, 8; H_SYNC, 4; H_BP, 43: horizontal front porch, sync and back porch in pixel slots, each >= 1.
REQ-003 Parameter V_ACTIVE, 272, visible lines per frame.
REQ-004 Parameter V_FP, 8; V_SYNC, 4; V_BP, 12: vertical front porch, sync and back porch in lines, each >= 1.
REQ-005 CLK  in  1  system clock; RSTn  in  1  reset, asynchronous, active-low.
REQ-006 PCLK_IN  in  1  divided pixel clock from the clock divider, synchronous to CLK, idles high after reset.
REQ-007 EN  in  1  timing enable; sampled only at frame boundary.
REQ-008 PIX_EN  out  1  one-CLK pulse per PCLK_IN rising edge (pixel slot strobe).
REQ-009 LCD_HS, LCD_VS  out  1 each  sync outputs, active-low.
REQ-010 LCD_DE  out  1  high during active pixel slots.
REQ-011 PIX_REQ  out  1  pixel-data request, one slot ahead of LCD_DE.
REQ-012 PIX_X, PIX_Y  out  11 each  coordinates of the pixel requested by PIX_REQ.
REQ-013 FRAME_START  out  1  one-CLK pulse at first slot of VSYNC phase.

Function
REQ-014 Rising edge of PCLK_IN SHALL be detected by a registered copy (reset value 1); PIX_EN = PCLK_IN & ~prev, no spurious pulse after reset.
REQ-015 All timing state SHALL advance only on CLK cycles with PIX_EN=1; outputs hold otherwise.
REQ-016 Horizontal FSM states HSYNC -> HBP -> HACT -> HFP -> HSYNC, dwell H_SYNC/H_BP/H_ACTIVE/H_FP slots; line = sum of four.
REQ-017 Vertical FSM states VSYNC -> VBP -> VACT -> VFP -> VSYNC, advancing on the last slot of HFP; dwell V_SYNC/V_BP/V_ACTIVE/V_FP lines.
REQ-018 Phase counters SHALL reset to 0 on each state entry; wrap with no off-by-one (a phase of N lasts exactly N slots/lines).
REQ-019 LCD_HS low during HSYNC; LCD_VS low during VSYNC; LCD_DE high iff HACT and VACT; all registered, changing in the PIX_EN cycle.
REQ-020 PIX_REQ high during the slot before each LCD_DE slot (last HBP slot through second-to-last HACT slot, VACT lines only).
REQ-021 PIX_X counts 0..H_ACTIVE-1 with PIX_REQ; PIX_Y = current active line 0..V_ACTIVE-1; both 0 outside requests.
REQ-022 EN low at frame end (last HFP slot of last VFP line) SHALL park FSMs in IDLE: HS, VS high, DE, PIX_REQ low; EN high in IDLE starts at VSYNC/HSYNC on next PIX_EN.
REQ-023 EN changes mid-frame SHALL NOT truncate the current frame.
REQ-024 FRAME_START SHALL pulse for one CLK together with the PIX_EN entering VSYNC/HSYNC.
REQ-025 PCLK_IN stalling high or low SHALL freeze all state without glitching outputs.

Reset
REQ-026 On RSTn low, immediately: FSMs IDLE, counters 0, LCD_HS=1, LCD_VS=1, LCD_DE=0, PIX_REQ=0, PIX_X=PIX_Y=0, PIX_EN=0, FRAME_START=0, edge register=1.
REQ-027 Reset mid-frame SHALL abort the frame; after release first frame starts at VSYNC on first PIX_EN with EN=1.

Structure
REQ-028 Shared package holds FSM state encodings (2-bit phase + IDLE), 11-bit coordinate width constant, default panel timing constants.
REQ-029 One sub-module, rgb_phase_cnt (phase FSM + counter, parameterised by four dwell lengths, with advance input and phase-done output), instantiated for horizontal and vertical.

Verification
REQ-030 H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, V_* =1, PCLK_IN toggling every 2 CLK, EN=1 -> line = 7 slots, frame = 35 slots, LCD_HS low 1 slot per line, LCD_VS low 7 slots per frame.
REQ-031 Same setup -> PIX_REQ leads LCD_DE by exactly one slot; PIX_X sequence 0,1,2,3 per active line; PIX_Y 0 then 1; 8 DE slots per frame.
REQ-032 Release reset with PCLK_IN=1 -> no PIX_EN until first 0->1 transition; FRAME_START on that slot.
REQ-033 Drop EN at mid-frame slot 10 -> frame completes all 35 slots, then IDLE outputs; raise EN -> next frame begins with FRAME_START on next PIX_EN.
REQ-034 Assert RSTn low during VACT with DE high -> DE=0, HS=VS=1 same cycle, no CLK edge required.
REQ-035 Hold PCLK_IN constant 20 CLK mid-line -> all outputs frozen, resume at identical position.
